// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I OP/OP-IMM issue, operand read and writeback unit
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] imm,
  output logic [4:0]  shamt,
  output logic [31:0] rv1,
  output logic [31:0] rv2,
  input  logic [31:0] valout,
  output logic        retire_valid,
  output logic        retire_illegal,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_data,
  output logic [31:0] retire_count,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] result;
  logic        legal;
  logic [31:0] regs [32];

  function automatic logic decode_legal(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    ok = 1'b0;
    case (op)
      7'b0010011: begin
        case (f3)
          3'b001:  ok = (f7 == 7'b0000000);
          3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: ok = 1'b1;
        endcase
      end
      7'b0110011: begin
        ok = (f7 == 7'b0000000) ||
             ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign imm    = ir[31:20];
  assign shamt  = ir[24:20];

  // regs[0] is never written, so reads of x0 naturally return 0
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      instr_ready    <= 1'b1;
      ir             <= 32'd0;
      rv1            <= 32'd0;
      rv2            <= 32'd0;
      result         <= 32'd0;
      legal          <= 1'b0;
      retire_valid   <= 1'b0;
      retire_illegal <= 1'b0;
      retire_rd      <= 5'd0;
      retire_data    <= 32'd0;
      retire_count   <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir          <= instr;
            instr_ready <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          rv1   <= regs[ir[19:15]];
          rv2   <= regs[ir[24:20]];
          legal <= decode_legal(ir);
          state <= EXEC;
        end
        EXEC: begin
          result         <= valout;
          retire_valid   <= 1'b1;
          retire_illegal <= ~legal;
          retire_rd      <= ir[11:7];
          retire_data    <= legal ? valout : 32'd0;
          state          <= WB;
        end
        WB: begin
          if (legal && (ir[11:7] != 5'd0)) begin
            regs[ir[11:7]] <= result;
          end
          if (legal) begin
            retire_count <= retire_count + 32'd1;
          end
          retire_valid   <= 1'b0;
          retire_illegal <= 1'b0;
          retire_rd      <= 5'd0;
          retire_data    <= 32'd0;
          instr_ready    <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized self-checking bench for alu_issue
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm;
  logic [4:0]  shamt;
  logic [31:0] rv1, rv2, valout;
  logic        retire_valid, retire_illegal;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data, retire_count;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .imm(imm), .shamt(shamt), .rv1(rv1), .rv2(rv2),
    .valout(valout), .retire_valid(retire_valid),
    .retire_illegal(retire_illegal), .retire_rd(retire_rd),
    .retire_data(retire_data), .retire_count(retire_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] alu(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [11:0] im,
                                      input logic [4:0] sh, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] bb;
    logic [4:0]  s;
    bb = (op == 7'h13) ? {{20{im[11]}}, im} : b;
    s  = (op == 7'h13) ? sh : b[4:0];
    case (f3)
      3'd0:    return (op == 7'h33 && f7 == 7'h20) ? a - bb : a + bb;
      3'd1:    return a << s;
      3'd2:    return ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
      3'd3:    return (a < bb) ? 32'd1 : 32'd0;
      3'd4:    return a ^ bb;
      3'd5:    return (f7 == 7'h20) ? $unsigned($signed(a) >>> s) : a >> s;
      3'd6:    return a | bb;
      default: return a & bb;
    endcase
  endfunction

  // Combinational ALU environment fed from the DUT's decoded fields
  assign valout = alu(opcode, funct3, funct7, imm, shamt, rv1, rv2);

  function automatic logic model_legal(input logic [31:0] w);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    if (op == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
      return 1'b1;
    end
    if (op == 7'h33) return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count = 32'd0;
  endtask

  task automatic model_step(input logic [31:0] w, output logic e_ill,
                            output logic [4:0] e_rd, output logic [31:0] e_data);
    logic lg;
    lg     = model_legal(w);
    e_ill  = ~lg;
    e_rd   = w[11:7];
    e_data = lg ? alu(w[6:0], w[14:12], w[31:25], w[31:20], w[24:20],
                      m_regs[w[19:15]], m_regs[w[24:20]]) : 32'd0;
    if (lg && e_rd != 5'd0) m_regs[e_rd] = e_data;
    if (lg) m_count = m_count + 32'd1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op, f7;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    op = (k < 5) ? 7'h13 : (k < 9) ? 7'h33 : r[6:0];
    k = $urandom_range(0, 3);
    f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : r[31:25];
    return {f7, r[24:7], op};
  endfunction

  // Drives one word from IDLE and observes its retirement; called at a negedge
  task automatic issue(input logic [31:0] w, output logic got, output logic [4:0] rd,
                       output logic [31:0] data, output logic ill, output int lat,
                       output logic stray);
    got = 1'b0; rd = 5'd0; data = 32'd0; ill = 1'b0; lat = 0; stray = 1'b0;
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
    if (!instr_ready) return;
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (instr_ready) stray = 1'b1;
      if (retire_valid) begin
        got = 1'b1; rd = retire_rd; data = retire_data; ill = retire_illegal;
      end else if (retire_illegal || retire_rd != 5'd0 || retire_data != 32'd0) begin
        stray = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || retire_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold ready=%b rv=%b exp 1 0", instr_ready, retire_valid);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || retire_valid !== 1'b0 || retire_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state ready=%b rv=%b cnt=%h exp 1 0 0", instr_ready, retire_valid, retire_count);
    end
    checks++;
    if ({opcode, funct3, funct7, imm, shamt} !== 34'd0 || rv1 !== 32'd0 || rv2 !== 32'd0) begin
      errors++; $display("FAIL reset_fields op=%h rv1=%h rv2=%h exp 0", opcode, rv1, rv2);
    end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      checks++;
      if (dbg_data !== 32'd0) begin
        errors++; $display("FAIL reset_reg x%0d got %h exp 0", a, dbg_data);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] words [5] = '{32'h00500093, 32'h00108133, 32'h401001B3, 32'h00700013, 32'h020002B3};
    logic [4:0]  erd   [5] = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd5};
    logic [31:0] edat  [5] = '{32'd5, 32'h0000000A, 32'hFFFFFFFB, 32'd7, 32'd0};
    logic        eill  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ecnt  [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd4};
    logic [31:0] eregs [6] = '{32'd0, 32'd5, 32'h0000000A, 32'hFFFFFFFB, 32'd0, 32'd0};
    logic got, ill, stray, mi;
    logic [4:0] rd, mr;
    logic [31:0] data, md;
    int lat;
    for (int i = 0; i < 5; i++) begin
      model_step(words[i], mi, mr, md);
      issue(words[i], got, rd, data, ill, lat, stray);
      checks++;
      if (!got || lat != 3 || stray) begin
        errors++; $display("FAIL dir_timing[%0d] got=%b lat=%0d stray=%b exp 1 3 0", i, got, lat, stray);
      end
      checks++;
      if (rd !== erd[i] || data !== edat[i] || ill !== eill[i]) begin
        errors++;
        $display("FAIL dir_retire[%0d] rd=%0d data=%h ill=%b exp %0d %h %b", i, rd, data, ill, erd[i], edat[i], eill[i]);
      end
      checks++;
      if (retire_count !== ecnt[i]) begin
        errors++; $display("FAIL dir_count[%0d] got %0d exp %0d", i, retire_count, ecnt[i]);
      end
    end
    for (int a = 0; a < 6; a++) begin
      dbg_addr = a[4:0];
      #1;
      checks++;
      if (dbg_data !== eregs[a]) begin
        errors++; $display("FAIL dir_reg x%0d got %h exp %h", a, dbg_data, eregs[a]);
      end
    end
  endtask

  task automatic test_random();
    logic got, ill, stray, mi;
    logic [4:0] rd, mr;
    logic [31:0] data, md, w;
    int lat;
    for (int n = 0; n < 80; n++) begin
      w = rand_instr();
      model_step(w, mi, mr, md);
      issue(w, got, rd, data, ill, lat, stray);
      checks++;
      if (!got || lat != 3 || stray || rd !== mr || data !== md || ill !== mi) begin
        errors++;
        $display("FAIL rand_retire w=%h got=%b lat=%0d rd=%0d data=%h ill=%b exp %0d %h %b",
                 w, got, lat, rd, data, ill, mr, md, mi);
      end
      checks++;
      if (retire_count !== m_count) begin
        errors++; $display("FAIL rand_count w=%h got %0d exp %0d", w, retire_count, m_count);
      end
      dbg_addr = mr;
      #1;
      checks++;
      if (dbg_data !== m_regs[mr]) begin
        errors++; $display("FAIL rand_reg x%0d got %h exp %h", mr, dbg_data, m_regs[mr]);
      end
    end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      checks++;
      if (dbg_data !== m_regs[a]) begin
        errors++; $display("FAIL rand_final x%0d got %h exp %h", a, dbg_data, m_regs[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    logic        eill [4];
    logic [4:0]  erd  [4];
    logic [31:0] edat [4];
    int acc [4];
    int idx = 0;
    int ret = 0;
    for (int i = 0; i < 4; i++) w[i] = rand_instr();
    w[1][6:0] = 7'h13;
    for (int cyc = 0; cyc < 40 && ret < 4; cyc++) begin
      @(negedge clk);
      instr_valid = (idx < 4);
      if (idx < 4) instr = w[idx];
      if (retire_valid) begin
        checks++;
        if (ret >= idx || retire_rd !== erd[ret] || retire_data !== edat[ret] || retire_illegal !== eill[ret]) begin
          errors++;
          $display("FAIL b2b_retire[%0d] rd=%0d data=%h ill=%b", ret, retire_rd, retire_data, retire_illegal);
        end
        ret++;
      end
      if (instr_ready) begin
        checks++;
        if (idx >= 4) begin
          errors++; $display("FAIL b2b_extra_ready cycle=%0d got 1 exp 0", cyc);
        end else begin
          model_step(w[idx], eill[idx], erd[idx], edat[idx]);
          acc[idx] = cyc;
          idx++;
        end
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (ret != 4 || idx != 4) begin
      errors++; $display("FAIL b2b_count retired=%0d accepted=%0d exp 4 4", ret, idx);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (i < idx && acc[i] - acc[i-1] != 4) begin
        errors++; $display("FAIL b2b_spacing[%0d] got %0d exp 4", i, acc[i] - acc[i-1]);
      end
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (retire_valid !== 1'b0 || instr_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_tail rv=%b ready=%b exp 0 1", retire_valid, instr_ready);
      end
    end
    checks++;
    if (retire_count !== m_count) begin
      errors++; $display("FAIL b2b_total got %0d exp %0d", retire_count, m_count);
    end
  endtask

  task automatic test_reset_midflight();
    instr = 32'h00500093;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (retire_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_pulse got %b exp 0", retire_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_ready got %b exp 1", instr_ready);
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (retire_valid !== 1'b0) begin
        errors++; $display("FAIL mid_rst_retire got %b exp 0", retire_valid);
      end
    end
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (dbg_data !== 32'd0 || retire_count !== 32'd0) begin
      errors++; $display("FAIL mid_rst_state x1=%h cnt=%0d exp 0 0", dbg_data, retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Multi-cycle issue and writeback unit for the single-cycle RV32I integer datapath. It accepts instruction words over a valid/ready handshake and holds the 32×32 integer register file. It decodes OP-IMM and OP instructions, drives the decoded fields and operands into the combinational ALU, captures the ALU result and writes it back to rd. One instruction is in flight at a time; it retires with a one-cycle status pulse.

## Interface
- No parameters (XLEN fixed at 32, 32 architectural registers).
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instr holds a valid instruction word
- instr  in  32  RV32I instruction word
- instr_ready  out  1  unit can accept an instruction (IDLE only)
- opcode  out  7  IR[6:0] to ALU
- funct3  out  3  IR[14:12] to ALU
- funct7  out  7  IR[31:25] to ALU
- imm  out  12  IR[31:20] to ALU (unextended; ALU sign-extends)
- shamt  out  5  IR[24:20] to ALU
- rv1  out  32  registered x[rs1] to ALU
- rv2  out  32  registered x[rs2] to ALU
- valout  in  32  combinational ALU result
- retire_valid  out  1  one-cycle pulse, instruction complete
- retire_illegal  out  1  qualifies retire_valid: instruction was not executed
- retire_rd  out  5  destination register of the retiring instruction
- retire_data  out  32  value written (0 when illegal)
- retire_count  out  32  count of legal retirements, wraps 0xFFFFFFFF→0
- dbg_addr  in  5  debug register-file read address
- dbg_data  out  32  combinational x[dbg_addr]; 0 for x0

## Operation
- Internal state: IR[31:0], rv1/rv2 registers, result register, legal flag, regfile x1..x31; x0 is hardwired 0 (never stored).
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready: IR←instr, go to READ. Otherwise stay in IDLE.
  - READ: rv1←x[IR[19:15]], rv2←x[IR[24:20]], legal←decode(IR). Go to EXEC.
  - EXEC: ALU fields and rv1/rv2 are stable. result←valout. Go to WB.
  - WB: retire_valid=1. If legal and rd≠0: x[rd]←result on the exiting edge. If legal: retire_count+1. Go to IDLE.
- The field outputs are driven continuously from IR; rv1/rv2 are driven continuously from their registers.
- Legal decode:
  - opcode 0010011 with funct3 ∈ {000,010,011,100,110,111}.
  - opcode 0010011, funct3=001 with funct7=0000000.
  - opcode 0010011, funct3=101 with funct7 ∈ {0000000,0100000}.
  - opcode 0110011 with funct7=0000000 and any funct3.
  - opcode 0110011 with funct7=0100000 and funct3 ∈ {000,101}.
  - Everything else is illegal.
- Illegal instruction: WB still pulses retire_valid with retire_illegal=1 and retire_data=0. No register write and no count increment.
- retire_rd=IR[11:7] during WB, including for illegal instructions and rd=0.
- A legal write to x0 retires normally: retire_data=result, count increments, x0 remains 0.
- retire_illegal, retire_rd and retire_data are valid only while retire_valid=1. They are 0 otherwise.

## Timing
- Handshake accepted at edge E0. READ occupies E0→E1, EXEC E1→E2, WB E2→E3 (retire_valid high in this cycle). The register write lands at E3. IDLE follows, so the next accept is at E4 at the earliest.
- Throughput is one instruction per 4 cycles. instr_ready falls the cycle after the accept and rises again after WB.
- RAW hazards cannot occur: the write at E3 precedes the next READ sample at E5 or later. No forwarding is required.
- Reset values:
  - State=IDLE, instr_ready=1.
  - IR=0, so opcode/funct3/funct7/imm/shamt=0.
  - rv1=rv2=0, regfile all 0.
  - retire_valid=retire_illegal=0, retire_rd=0, retire_data=0, retire_count=0.
- Reset asserted in any state: immediately forces all reset values. An in-flight instruction is discarded with no retire pulse and no write.
- instr_valid held high across WB→IDLE: the word is accepted exactly once per IDLE visit. instr is not sampled in other states.
- dbg_data is combinational. It reflects a write starting the cycle after E3.

## Test plan
- Reset, then hold idle: instr_ready=1, retire_valid=0, retire_count=0, dbg_data=0 for dbg_addr 0..31.
- Send 0x00500093 (ADDI x1,x0,5): retire_valid exactly 3 cycles after the accept edge with retire_rd=1, retire_data=5, retire_illegal=0. After that, dbg x1=5 and retire_count=1.
- Then send 0x00108133 (ADD x2,x1,x1) and 0x401001B3 (SUB x3,x0,x1): x2=0x0000000A, x3=0xFFFFFFFB, retire_count=3.
- Send 0x00700013 (ADDI x0,x0,7): retire_rd=0, retire_data=7, x0 reads 0, retire_count increments. Send 0x020002B3 (MUL x5): retire_illegal=1, retire_data=0, x5 unchanged, count unchanged.
- Hold instr_valid=1 over a 4-instruction stream: instr_ready high one cycle in every 4, each word retires exactly once, in order.
- Assert rst during EXEC of 0x00500093: no retire pulse, x1=0, retire_count=0, instr_ready=1 on the first cycle after rst deasserts.
